// File: rtl/glyph_plotter.sv
// Renders a latched 16x16 monochrome glyph into the 160x120 framebuffer,
// one registered write per cycle in row-major order, clipping off-screen pixels.
module glyph_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] glyph_in,
    input  logic [7:0]   x_origin,
    input  logic [6:0]   y_origin,
    input  logic [2:0]   fg_colour,
    input  logic [2:0]   bg_colour,
    input  logic         transparent,
    output logic [7:0]   x,
    output logic [6:0]   y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         done
);

    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t       r_state;
    state_t       w_nextState;

    logic [255:0] r_glyph;
    logic [7:0]   r_xOrigin;
    logic [6:0]   r_yOrigin;
    logic [2:0]   r_fgColour;
    logic [2:0]   r_bgColour;
    logic         r_transparent;
    logic [7:0]   r_n;

    logic [7:0]   r_x;
    logic [6:0]   r_y;
    logic [2:0]   r_colour;
    logic         r_plot;
    logic         r_busy;
    logic         r_done;

    logic [8:0]   w_xSum;
    logic [7:0]   w_ySum;
    logic         w_inBounds;
    logic         w_bit;
    logic [7:0]   w_x;
    logic [6:0]   w_y;
    logic [2:0]   w_colour;
    logic         w_plot;
    logic         w_busy;
    logic         w_done;

    // Sums are one bit wider than the outputs so the clip test sees carries.
    assign w_xSum     = {1'b0, r_xOrigin} + {5'b0, r_n[3:0]};
    assign w_ySum     = {1'b0, r_yOrigin} + {4'b0, r_n[7:4]};
    assign w_inBounds = (w_xSum < X_LIMIT) && (w_ySum < Y_LIMIT);
    assign w_bit      = r_glyph[r_n];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = DRAW;
            DRAW:    if (r_n == 8'hFF) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_x      = r_x;
        w_y      = r_y;
        w_colour = r_colour;
        w_plot   = 1'b0;
        w_busy   = (r_state != IDLE);
        w_done   = (r_state == DONE);
        if (r_state == DRAW) begin
            w_x      = w_xSum[7:0];
            w_y      = w_ySum[6:0];
            w_colour = w_bit ? r_fgColour : r_bgColour;
            w_plot   = w_inBounds && (w_bit || !r_transparent);
        end
    end

    // Glyph and colours are captured once so the caller may move on immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_glyph       <= '0;
            r_xOrigin     <= '0;
            r_yOrigin     <= '0;
            r_fgColour    <= '0;
            r_bgColour    <= '0;
            r_transparent <= 1'b0;
            r_n           <= '0;
        end else if (r_state == IDLE && start) begin
            r_glyph       <= glyph_in;
            r_xOrigin     <= x_origin;
            r_yOrigin     <= y_origin;
            r_fgColour    <= fg_colour;
            r_bgColour    <= bg_colour;
            r_transparent <= transparent;
            r_n           <= '0;
        end else if (r_state == DRAW) begin
            r_n <= r_n + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= w_colour;
            r_plot   <= w_plot;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter: a table of draws checked pixel by pixel,
// plus hand sequences for start-while-busy, back-to-back starts and mid-draw reset.
module tb_glyph_plotter;

    logic         clk;
    logic         reset;
    logic         start;
    logic [255:0] glyph_in;
    logic [7:0]   x_origin;
    logic [6:0]   y_origin;
    logic [2:0]   fg_colour;
    logic [2:0]   bg_colour;
    logic         transparent;
    logic [7:0]   x;
    logic [6:0]   y;
    logic [2:0]   colour;
    logic         plot;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    typedef struct {
        logic [255:0] glyph;
        logic [7:0]   xo;
        logic [6:0]   yo;
        logic [2:0]   fg;
        logic [2:0]   bg;
        logic         tr;
        int           expPlots;
        int           mode;
        int           chain;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    glyph_plotter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .glyph_in    (glyph_in),
        .x_origin    (x_origin),
        .y_origin    (y_origin),
        .fg_colour   (fg_colour),
        .bg_colour   (bg_colour),
        .transparent (transparent),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        glyph_in    = v.glyph;
        x_origin    = v.xo;
        y_origin    = v.yo;
        fg_colour   = v.fg;
        bg_colour   = v.bg;
        transparent = v.tr;
        start       = 1'b1;
    endtask

    // Precondition: start is asserted and the next rising edge is E0.
    task automatic drawAndCheck(input int idx, input int nextIdx);
        vec_t v;
        int   plots;
        int   xs;
        int   ys;
        logic b;
        logic ep;
        logic [2:0] ec;
        v = vecs[idx];
        plots = 0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput($sformatf("v%0d_e0_state", idx), 32'({busy, done, plot}), 32'h0);
        if (v.mode == 1) begin
            glyph_in  = ~v.glyph;
            fg_colour = ~v.fg;
            x_origin  = v.xo + 8'd7;
        end
        for (int n = 0; n < 256; n++) begin
            @(posedge clk); #1;
            xs = int'(v.xo) + (n % 16);
            ys = int'(v.yo) + (n / 16);
            b  = v.glyph[n];
            ep = (xs < 160) && (ys < 120) && (b || !v.tr);
            ec = b ? v.fg : v.bg;
            if (plot) plots++;
            if (ep) begin
                checkOutput($sformatf("v%0d_pixel%0d", idx, n),
                            32'({busy, done, plot, x, y, colour}),
                            32'({3'b101, 8'(xs), 7'(ys), ec}));
            end else begin
                checkOutput($sformatf("v%0d_noplot%0d", idx, n),
                            32'({busy, done, plot}), 32'h4);
            end
            if (v.mode == 2 && n == 98) begin
                glyph_in = {8{32'hDEAD_BEEF}};
                x_origin = 8'd3;
                y_origin = 7'd3;
                fg_colour = 3'd7;
                start = 1'b1;
            end
            if (v.mode == 2 && n == 99) start = 1'b0;
        end
        checkOutput($sformatf("v%0d_plot_count", idx), 32'(plots), 32'(v.expPlots));
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_done_pulse", idx), 32'({busy, done, plot}), 32'h6);
        if (nextIdx >= 0) begin
            applyStimulus(vecs[nextIdx]);
        end else begin
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_after_done", idx), 32'({busy, done, plot}), 32'h0);
        end
    endtask

    initial begin
        logic [255:0] fGlyph;
        logic         chained;
        int           activity;

        checks = 0;
        errors = 0;

        fGlyph = '0;
        fGlyph[16*3 +: 16] = 16'h0020;
        for (int r = 4; r <= 11; r++) fGlyph[16*r +: 16] = 16'h0020;
        fGlyph[16*7 +: 16]  = 16'h00E0;
        fGlyph[16*12 +: 16] = 16'h07E0;

        //           glyph                   xo     yo     fg    bg    tr  plots mode chain
        vecs[0] = '{256'd1,                  8'd10, 7'd20, 3'd4, 3'd0, 1'b0, 256, 0, -1};
        vecs[1] = '{fGlyph,                  8'd0,  7'd0,  3'd2, 3'd5, 1'b1,  17, 0, -1};
        vecs[2] = '{{256{1'b1}},             8'd150,7'd110,3'd3, 3'd1, 1'b0, 100, 0, -1};
        vecs[3] = '{{16{16'hA5C3}},          8'd40, 7'd30, 3'd1, 3'd6, 1'b0, 256, 1, -1};
        vecs[4] = '{{8{32'h0F0F_1234}},      8'd100,7'd50, 3'd6, 3'd2, 1'b0, 256, 2,  5};
        vecs[5] = '{{256{1'b1}},             8'd145,7'd0,  3'd5, 3'd0, 1'b0, 240, 0, -1};
        vecs[6] = '{fGlyph,                  8'd158,7'd118,3'd7, 3'd1, 1'b1,   0, 0, -1};
        vecs[7] = '{{256{1'b1}},             8'd0,  7'd105,3'd2, 3'd4, 1'b0, 240, 0, -1};

        reset       = 1'b1;
        start       = 1'b0;
        glyph_in    = '0;
        x_origin    = '0;
        y_origin    = '0;
        fg_colour   = '0;
        bg_colour   = '0;
        transparent = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'({busy, done, plot, x, y, colour}), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_no_start", 32'({busy, done, plot}), 32'h0);

        chained = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (!chained) applyStimulus(vecs[i]);
            drawAndCheck(i, vecs[i].chain);
            chained = (vecs[i].chain >= 0);
        end

        // Reset sampled at E50 must abort the draw with no done pulse.
        applyStimulus(vecs[2]);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_state", 32'({busy, done, plot, x, y, colour}), 32'h0);
        reset = 1'b0;
        activity = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (plot || done || busy) activity++;
        end
        checkOutput("midreset_quiet", 32'(activity), 32'h0);

        applyStimulus(vecs[0]);
        drawAndCheck(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_plotter.md
# glyph_plotter

Pixel sequencer that renders one 16x16 monochrome glyph bitmap, as produced by the piece-character decoder, into the 160x120 VGA framebuffer. On a start strobe it latches the 256-bit glyph, a screen origin and a colour pair, then issues one framebuffer write per cycle, row-major, for 256 cycles. It sits between the board-drawing controller, which selects a cell and piece, and the VGA adapter write port (x, y, colour, plot).

## Interface

Parameters:
- `SCREEN_W`, 160: framebuffer width; pixels with x >= SCREEN_W are clipped.
- `SCREEN_H`, 120: framebuffer height; pixels with y >= SCREEN_H are clipped.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to draw; sampled only in IDLE.
- `glyph_in` in 256: bitmap; pixel (col c, row r) = `glyph_in[16*r + c]`, with c and r in 0..15.
- `x_origin` in 8: screen x of glyph column 0.
- `y_origin` in 7: screen y of glyph row 0.
- `fg_colour` in 3: colour for set bits.
- `bg_colour` in 3: colour for clear bits.
- `transparent` in 1: 1 = clear bits are not written.
- `x` out 8: framebuffer write x.
- `y` out 7: framebuffer write y.
- `colour` out 3: framebuffer write colour.
- `plot` out 1: framebuffer write enable.
- `busy` out 1: high in DRAW and DONE.
- `done` out 1: one-cycle completion pulse.

## Operation

- FSM states: IDLE, DRAW, DONE.
- IDLE, `start`=1:
  - Latch `glyph_in`, `x_origin`, `y_origin`, `fg_colour`, `bg_colour` and `transparent` into internal registers.
  - Clear the 8-bit pixel counter n.
  - Go to DRAW.
- IDLE, `start`=0: remain in IDLE.
- Inputs are don't-care after the latch. They may change freely during a draw.
- DRAW, each cycle, for counter value n:
  - col = n[3:0], row = n[7:4].
  - bit = latched glyph[n].
  - Register outputs:
    - x = x_origin + col.
    - y = y_origin + row.
    - colour = bit ? fg : bg.
    - plot = in_bounds && (bit || !transparent).
  - Increment n.
  - Compute the sums at 9 bits (x) and 8 bits (y). in_bounds = (x_sum < SCREEN_W) && (y_sum < SCREEN_H).
  - When plot=0 because of clipping, the x and y outputs carry the truncated sum. Their value is don't-care.
- DRAW with n=255: emit the last pixel, then go to DONE.
- DONE: `done`=1 and `plot`=0 for exactly one cycle, then go to IDLE.
- `start` is ignored in DRAW and DONE. A request is never queued.
- `reset` has priority over everything, including mid-draw:
  - State returns to IDLE.
  - n = 0.
  - No further pixels are emitted.
- Register values after reset: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0. The latched glyph and colour registers are cleared to 0.

## Timing

- Let E0 be the edge that samples `start`=1 in IDLE.
- Pixel n (0..255) is presented on x/y/colour/plot in the cycle after edge E(n+1).
- `busy`=1 from E1 through the DONE cycle. `busy` drops at E258.
- `done`=1 in the cycle after E257. This is the only cycle with `done`=1.
- The earliest next start is sampled at E258. Draw-to-draw throughput is 258 cycles per glyph.
- Output order is row 0 col 0..15, then row 1, and so on to row 15 col 15. Successive pixels are never skipped or repeated.
- `plot` is never high outside DRAW.
- No backpressure exists. The VGA adapter accepts one write per cycle.

## Test plan

- **Single-bit glyph.** glyph=1, origin (10,20), fg=3'b100, bg=0, transparent=0, start at E0.
  - After E1: plot=1, x=10, y=20, colour=4.
  - After E2..E256: 255 writes with colour=0.
  - done after E257.
  - busy low after E258.
- **Transparent 'F' glyph.** Load the 'F' bitmap (row 3 = 16'h0020 ... row 12 = 16'h07E0), origin (0,0), transparent=1.
  - Writes occur exactly for the set bits: 17 total, each with colour=fg.
  - Set positions match `glyph_in[16r+c]`.
  - No other plot pulses.
- **Clipping.** All-ones glyph, origin (150,110), transparent=0.
  - Plot only where x in 150..159 and y in 110..119: 100 writes.
  - No write with x >= 160 or y >= 120.
- **Start while busy.** Start again at E100 with a different glyph and origin.
  - The draw continues unchanged with the first glyph.
  - done after E257.
  - A start at E258 begins a new draw with pixel 0 after E259.
- **Input change after latch.** Change `glyph_in`, `fg_colour` and `x_origin` at E1.
  - All 256 writes use the values latched at E0.
- **Reset mid-draw.** reset=1 at E50.
  - From the cycle after E50: plot=0, busy=0, done=0, x=y=colour=0.
  - No done pulse follows.
  - A start after reset draws normally from pixel 0.
